snake_segment_engine: RTL and testbench

Parametrised multi-segment snake body engine for the VGA snake game. It replaces the single-square snake movers with a full body of up to MAX_LEN grid-aligned segments, driven by keyboard direction on each frame tick. It also provides wrap-around at the screen edges, growth on request, sequential self-collision detection, and a registered per-pixel hit query for the colour mapper. It sits between the USB keycode export and the colour mapper, one instance per player.

---
 rtl/snake_segment_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_snake_segment_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_segment_engine.sv
// snake_segment_engine: grid-aligned multi-segment snake body with
// wrap-around moves, growth, self-collision scan and pixel hit query.
module snake_segment_engine #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int SEG_SIZE = 8,
  parameter int X_CELLS  = 80,
  parameter int Y_CELLS  = 60,
  parameter int START_X  = 320,
  parameter int START_Y  = 240
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_tick,
  input  logic                         pause,
  input  logic                         grow,
  input  logic [7:0]                   keycode,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  output logic                         hit,
  output logic                         head_hit,
  output logic [9:0]                   head_x,
  output logic [9:0]                   head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         busy,
  output logic                         alive
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  localparam logic [9:0] STEP  = 10'(SEG_SIZE);
  localparam logic [9:0] X_MAX = 10'((X_CELLS - 1) * SEG_SIZE);
  localparam logic [9:0] Y_MAX = 10'((Y_CELLS - 1) * SEG_SIZE);

  // Opposite directions differ only in bit 0.
  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_DEAD
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    seg_x_q [MAX_LEN];
  logic [9:0]    seg_x_d [MAX_LEN];
  logic [9:0]    seg_y_q [MAX_LEN];
  logic [9:0]    seg_y_d [MAX_LEN];
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    pdir_q, pdir_d;
  logic          tick_pend_q, tick_pend_d;
  logic          grow_pend_q, grow_pend_d;
  logic          alive_q, alive_d;
  logic          hit_q, hit_d;
  logic          head_hit_q, head_hit_d;

  logic          key_vld;
  logic [1:0]    key_dir;
  logic [9:0]    nxt_x, nxt_y;
  logic [IW-1:0] idx_sel;
  logic          scan_match;
  logic          can_grow;
  logic          tick_ok;
  logic [MAX_LEN-1:0] in_seg;
  logic [MAX_LEN-1:0] act;

  assign idx_sel  = idx_q[IW-1:0];
  assign can_grow = len_q < LW'(MAX_LEN);
  assign tick_ok  = frame_tick & ~pause;

  assign scan_match = (idx_q < len_q)
                    && (seg_x_q[idx_sel] == seg_x_q[0])
                    && (seg_y_q[idx_sel] == seg_y_q[0]);

  // Keycode to direction decode; unknown codes are not valid.
  always_comb begin
    key_vld = 1'b1;
    key_dir = D_RIGHT;
    unique case (1'b1)
      keycode == 8'h1A: key_dir = D_UP;
      keycode == 8'h16: key_dir = D_DOWN;
      keycode == 8'h04: key_dir = D_LEFT;
      keycode == 8'h07: key_dir = D_RIGHT;
      default:          key_vld = 1'b0;
    endcase
  end

  // Next head position with wrap at the grid edges.
  always_comb begin
    nxt_x = seg_x_q[0];
    nxt_y = seg_y_q[0];
    unique case (pdir_q)
      D_UP:
        nxt_y = (seg_y_q[0] == '0) ? Y_MAX
                                   : seg_y_q[0] - STEP;
      D_DOWN:
        nxt_y = (seg_y_q[0] == Y_MAX) ? '0
                                      : seg_y_q[0] + STEP;
      D_LEFT:
        nxt_x = (seg_x_q[0] == '0) ? X_MAX
                                   : seg_x_q[0] - STEP;
      D_RIGHT:
        nxt_x = (seg_x_q[0] == X_MAX) ? '0
                                      : seg_x_q[0] + STEP;
    endcase
  end

  // Move / scan / death control and body update.
  always_comb begin
    state_d     = state_q;
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    len_d       = len_q;
    idx_d       = idx_q;
    dir_d       = dir_q;
    pdir_d      = pdir_q;
    tick_pend_d = tick_pend_q;
    grow_pend_d = grow_pend_q;
    alive_d     = alive_q;

    if (state_q != S_DEAD && key_vld
        && key_dir != (dir_q ^ 2'b01))
      pdir_d = key_dir;

    unique case (state_q)
      S_IDLE: begin
        if (tick_ok | tick_pend_q) begin
          dir_d = pdir_q;
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = nxt_x;
          seg_y_d[0] = nxt_y;
          if ((grow | grow_pend_q) & can_grow)
            len_d = len_q + LW'(1);
          grow_pend_d = 1'b0;
          tick_pend_d = 1'b0;
          idx_d       = LW'(1);
          state_d     = S_CHECK;
        end else if (grow & can_grow) begin
          grow_pend_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (tick_ok)
          tick_pend_d = 1'b1;
        if (grow & can_grow)
          grow_pend_d = 1'b1;
        if (scan_match) begin
          alive_d = 1'b0;
          state_d = S_DEAD;
        end else if (idx_q >= len_q - LW'(1)) begin
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      default: ;
    endcase
  end

  // Per-pixel containment against every active segment.
  always_comb begin
    in_seg = '0;
    act    = '0;
    for (int j = 0; j < MAX_LEN; j++) begin
      in_seg[j] = ({1'b0, DrawX} >= {1'b0, seg_x_q[j]})
               && ({1'b0, DrawX} < {1'b0, seg_x_q[j]} + 11'(SEG_SIZE))
               && ({1'b0, DrawY} >= {1'b0, seg_y_q[j]})
               && ({1'b0, DrawY} < {1'b0, seg_y_q[j]} + 11'(SEG_SIZE));
      act[j]    = LW'(j) < len_q;
    end
    hit_d      = |(in_seg & act);
    head_hit_d = in_seg[0];
  end

  // State registers with asynchronous reset to the start body.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= 10'(START_X - i * SEG_SIZE);
        seg_y_q[i] <= 10'(START_Y);
      end
      len_q       <= LW'(INIT_LEN);
      idx_q       <= LW'(1);
      dir_q       <= D_RIGHT;
      pdir_q      <= D_RIGHT;
      tick_pend_q <= 1'b0;
      grow_pend_q <= 1'b0;
      alive_q     <= 1'b1;
      hit_q       <= 1'b0;
      head_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      dir_q       <= dir_d;
      pdir_q      <= pdir_d;
      tick_pend_q <= tick_pend_d;
      grow_pend_q <= grow_pend_d;
      alive_q     <= alive_d;
      hit_q       <= hit_d;
      head_hit_q  <= head_hit_d;
    end
  end

  assign hit      = hit_q;
  assign head_hit = head_hit_q;
  assign head_x   = seg_x_q[0];
  assign head_y   = seg_y_q[0];
  assign length   = len_q;
  assign busy     = (state_q == S_CHECK);
  assign alive    = alive_q;

endmodule

// File: tb/tb_snake_segment_engine.sv
// tb_snake_segment_engine: two engines (INIT_LEN 3 and 5) checked
// each cycle against a list-of-cells snake model plus literal pins.
module tb_snake_segment_engine;

  logic       clk;
  logic       rst_n;
  logic [1:0] tick;
  logic [1:0] pse;
  logic [1:0] grw;
  logic [7:0] key [2];
  logic [9:0] dx [2];
  logic [9:0] dy [2];

  logic [1:0] hit_o;
  logic [1:0] hh_o;
  logic [1:0] busy_o;
  logic [1:0] alive_o;
  logic [9:0] hx_o [2];
  logic [9:0] hy_o [2];
  logic [4:0] len_o [2];

  int passed = 0;
  int total  = 0;

  snake_segment_engine u0 (
    .Clk(clk), .Reset_n(rst_n),
    .frame_tick(tick[0]), .pause(pse[0]), .grow(grw[0]),
    .keycode(key[0]), .DrawX(dx[0]), .DrawY(dy[0]),
    .hit(hit_o[0]), .head_hit(hh_o[0]),
    .head_x(hx_o[0]), .head_y(hy_o[0]),
    .length(len_o[0]), .busy(busy_o[0]), .alive(alive_o[0])
  );

  snake_segment_engine #(.INIT_LEN(5)) u1 (
    .Clk(clk), .Reset_n(rst_n),
    .frame_tick(tick[1]), .pause(pse[1]), .grow(grw[1]),
    .keycode(key[1]), .DrawX(dx[1]), .DrawY(dy[1]),
    .hit(hit_o[1]), .head_hit(hh_o[1]),
    .head_x(hx_o[1]), .head_y(hy_o[1]),
    .length(len_o[1]), .busy(busy_o[1]), .alive(alive_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int sx [2][16];
  int sy [2][16];
  int mlen [2];
  int mbusy [2];
  int mdx [2], mdy [2], mpx [2], mpy [2];
  bit mdead [2], mcoll [2], mtp [2], mgp [2];
  bit mhit [2], mhh [2];

  function automatic bit in_cell(int k, int j);
    int px = int'(dx[k]);
    int py = int'(dy[k]);
    return px >= sx[k][j] && px < sx[k][j] + 8
        && py >= sy[k][j] && py < sy[k][j] + 8;
  endfunction

  task automatic model_reset(input int k);
    mlen[k] = (k == 0) ? 3 : 5;
    for (int i = 0; i < 16; i++) begin
      sx[k][i] = 320 - 8 * i;
      sy[k][i] = 240;
    end
    mdx[k] = 1; mdy[k] = 0;
    mpx[k] = 1; mpy[k] = 0;
    mbusy[k] = 0; mdead[k] = 0; mcoll[k] = 0;
    mtp[k] = 0; mgp[k] = 0; mhit[k] = 0; mhh[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit kv, tk;
    int kx, ky, npx, npy;
    mhit[k] = 0;
    for (int j = 0; j < mlen[k]; j++)
      if (in_cell(k, j)) mhit[k] = 1;
    mhh[k] = in_cell(k, 0);
    if (mdead[k]) return;
    kv = 1; kx = 0; ky = 0;
    case (key[k])
      8'h1A:   ky = -1;
      8'h16:   ky = 1;
      8'h04:   kx = -1;
      8'h07:   kx = 1;
      default: kv = 0;
    endcase
    npx = mpx[k]; npy = mpy[k];
    if (kv && !(kx == -mdx[k] && ky == -mdy[k])) begin
      npx = kx; npy = ky;
    end
    tk = tick[k] && !pse[k];
    if (mbusy[k] > 0) begin
      if (tk) mtp[k] = 1;
      if (grw[k] && mlen[k] < 16) mgp[k] = 1;
      mbusy[k]--;
      if (mbusy[k] == 0 && mcoll[k]) mdead[k] = 1;
    end else if (tk || mtp[k]) begin
      mdx[k] = mpx[k]; mdy[k] = mpy[k];
      for (int i = 15; i > 0; i--) begin
        sx[k][i] = sx[k][i-1];
        sy[k][i] = sy[k][i-1];
      end
      sx[k][0] = (sx[k][0] + 8 * mdx[k] + 640) % 640;
      sy[k][0] = (sy[k][0] + 8 * mdy[k] + 480) % 480;
      if ((grw[k] || mgp[k]) && mlen[k] < 16) mlen[k]++;
      mgp[k] = 0; mtp[k] = 0; mcoll[k] = 0;
      mbusy[k] = (mlen[k] > 1) ? mlen[k] - 1 : 1;
      for (int i = 1; i < mlen[k]; i++) begin
        if (sx[k][i] == sx[k][0] && sy[k][i] == sy[k][0]) begin
          mcoll[k] = 1;
          mbusy[k] = i;
          break;
        end
      end
    end else if (grw[k] && mlen[k] < 16) begin
      mgp[k] = 1;
    end
    mpx[k] = npx; mpy[k] = npy;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) model_reset(k);
        else model_step(k);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m_head_x%0d", k), int'(hx_o[k]), sx[k][0]);
        chk($sformatf("m_head_y%0d", k), int'(hy_o[k]), sy[k][0]);
        chk($sformatf("m_len%0d", k), int'(len_o[k]), mlen[k]);
        chk($sformatf("m_busy%0d", k), int'(busy_o[k]), int'(mbusy[k] > 0));
        chk($sformatf("m_alive%0d", k), int'(alive_o[k]), int'(!mdead[k]));
        chk($sformatf("m_hit%0d", k), int'(hit_o[k]), int'(mhit[k]));
        chk($sformatf("m_hhit%0d", k), int'(hh_o[k]), int'(mhh[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input int k, input bit t, input bit g);
    tick[k] = t;
    grw[k]  = g;
    @(negedge clk);
    tick[k] = 1'b0;
    grw[k]  = 1'b0;
  endtask

  task automatic press(input int k, input logic [7:0] code);
    key[k] = code;
    repeat (2) @(negedge clk);
    key[k] = 8'h00;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy_o[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_wait%0d", k), int'(busy_o[k]), 0);
  endtask

  task automatic move(input int k);
    pulse(k, 1'b1, 1'b0);
    wait_idle(k);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int y0;
    rst_n = 1'b0;
    tick  = '0;
    pse   = '0;
    grw   = '0;
    for (int k = 0; k < 2; k++) begin
      key[k] = 8'h00;
      dx[k]  = '0;
      dy[k]  = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_head_x", int'(hx_o[0]), 320);
    chk("rst_head_y", int'(hy_o[0]), 240);
    chk("rst_len", int'(len_o[0]), 3);
    chk("rst_len5", int'(len_o[1]), 5);
    chk("rst_alive", int'(alive_o[0]), 1);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_hit", int'(hit_o[0]), 0);
    rst_n = 1'b1;

    dx[0] = 10'd323; dy[0] = 10'd243;
    @(negedge clk);
    chk("q_head_hit", int'(hh_o[0]), 1);
    chk("q_head_any", int'(hit_o[0]), 1);
    dx[0] = 10'd312;
    @(negedge clk);
    chk("q_body_hit", int'(hit_o[0]), 1);
    chk("q_body_head", int'(hh_o[0]), 0);
    dx[0] = 10'd328;
    @(negedge clk);
    chk("q_miss", int'(hit_o[0]), 0);

    // Self-collision on the INIT_LEN=5 engine.
    press(1, 8'h1A); move(1);
    press(1, 8'h04); move(1);
    press(1, 8'h16); pulse(1, 1'b1, 1'b0);
    chk("coll_head_x", int'(hx_o[1]), 312);
    chk("coll_head_y", int'(hy_o[1]), 240);
    n = 0;
    while (alive_o[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("death_cycles", n, 4);
    chk("dead_busy", int'(busy_o[1]), 0);
    press(1, 8'h1A);
    pulse(1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("dead_hold_x", int'(hx_o[1]), 312);
    chk("dead_hold_y", int'(hy_o[1]), 240);
    chk("dead_len", int'(len_o[1]), 5);

    // Single move and busy window.
    pulse(0, 1'b1, 1'b0);
    chk("mv_head_x", int'(hx_o[0]), 328);
    chk("mv_busy1", int'(busy_o[0]), 1);
    @(negedge clk);
    chk("mv_busy2", int'(busy_o[0]), 1);
    dx[0] = 10'd312; dy[0] = 10'd240;
    @(negedge clk);
    chk("mv_busy3", int'(busy_o[0]), 0);
    @(negedge clk);
    chk("mv_seg2_hit", int'(hit_o[0]), 1);
    dx[0] = 10'd304;
    @(negedge clk);
    chk("mv_old_tail", int'(hit_o[0]), 0);

    press(0, 8'h04); move(0);
    chk("rev_head_x", int'(hx_o[0]), 336);
    press(0, 8'h1A); move(0);
    chk("up_head_x", int'(hx_o[0]), 336);
    chk("up_head_y", int'(hy_o[0]), 232);
    press(0, 8'h07); move(0);
    chk("rt_head_x", int'(hx_o[0]), 344);
    repeat (36) move(0);
    chk("edge_x", int'(hx_o[0]), 632);
    move(0);
    chk("wrap_x", int'(hx_o[0]), 0);
    press(0, 8'h1A);
    repeat (29) move(0);
    chk("edge_y", int'(hy_o[0]), 0);
    move(0);
    chk("wrap_y", int'(hy_o[0]), 472);
    chk("wrap_y_x", int'(hx_o[0]), 0);

    // Growth: pending, same-cycle, during scan, saturation.
    pulse(0, 1'b0, 1'b1);
    move(0);
    chk("grow_len4", int'(len_o[0]), 4);
    dx[0] = 10'd3; dy[0] = 10'd10;
    @(negedge clk);
    chk("grow_seg3_hit", int'(hit_o[0]), 1);
    chk("grow_seg3_head", int'(hh_o[0]), 0);
    pulse(0, 1'b1, 1'b1);
    wait_idle(0);
    chk("grow_len5", int'(len_o[0]), 5);
    pulse(0, 1'b1, 1'b0);
    pulse(0, 1'b0, 1'b1);
    wait_idle(0);
    chk("grow_late_len", int'(len_o[0]), 5);
    move(0);
    chk("grow_late_len6", int'(len_o[0]), 6);
    repeat (16) begin
      pulse(0, 1'b1, 1'b1);
      wait_idle(0);
    end
    chk("grow_sat", int'(len_o[0]), 16);
    chk("grow_alive", int'(alive_o[0]), 1);

    // Tick during scan is served right after.
    y0 = int'(hy_o[0]);
    pulse(0, 1'b1, 1'b0);
    pulse(0, 1'b1, 1'b0);
    repeat (45) @(negedge clk);
    chk("late_tick_y", int'(hy_o[0]), (y0 + 480 - 16) % 480);
    chk("late_tick_busy", int'(busy_o[0]), 0);

    // Paused ticks are dropped.
    y0 = int'(hy_o[0]);
    pse[0] = 1'b1;
    pulse(0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    pse[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pause_y", int'(hy_o[0]), y0);
    chk("pause_busy", int'(busy_o[0]), 0);

    // Asynchronous reset in the middle of a scan.
    pulse(0, 1'b1, 1'b0);
    tick[0] = 1'b1;
    grw[0]  = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_head_x", int'(hx_o[0]), 320);
    chk("ar_head_y", int'(hy_o[0]), 240);
    chk("ar_len", int'(len_o[0]), 3);
    chk("ar_busy", int'(busy_o[0]), 0);
    chk("ar_alive1", int'(alive_o[1]), 1);
    tick[0] = 1'b0;
    grw[0]  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("ar_no_pend_x", int'(hx_o[0]), 320);
    chk("ar_no_pend_len", int'(len_o[0]), 3);
    chk("ar_no_pend_busy", int'(busy_o[0]), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
